// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin owner scheduler for a shared 8-to-1 mux.
// Grants one requester at a time, caps each grant at MAX_HOLD cycles,
// and always inserts one dead cycle (en = 0) between owners.
module mux8_rr_sched #(
  parameter int MAX_HOLD = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic       i_done,
  output logic [2:0] o_sel,
  output logic       o_en,
  output logic [7:0] o_grant,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hcnt;
  logic [2:0] r_sel;
  logic       r_en;
  logic [7:0] r_grant;
  logic       r_busy;

  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic        w_found;
  logic [2:0]  w_off;
  logic [2:0]  w_winner;
  logic        w_release;

  // Rotate the request vector so bit 0 is the requester at the pointer;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  assign w_dbl = {i_req, i_req};
  assign w_rot = 8'(w_dbl >> r_ptr);

  // Priority scan of the rotated requests (lowest offset wins).
  always_comb begin
    w_found = |w_rot;
    w_off   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 3'(k);
      end
    end
  end

  // 3-bit addition wraps naturally from 7 back to 0.
  assign w_winner = r_ptr + w_off;

  // Any release cause ends the grant; several at once still give one release.
  assign w_release = i_done | ~i_req[r_sel] | (r_hcnt == 8'(MAX_HOLD));

  // Scheduler FSM with registered mux controls; sel is only updated on a new grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_hcnt  <= 8'd0;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_grant <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_sel   <= w_winner;
            r_grant <= 8'(1) << w_winner;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_hcnt  <= 8'd1;
            r_ptr   <= w_winner + 3'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state <= S_GAP;
            r_en    <= 1'b0;
            r_grant <= 8'h00;
            r_busy  <= 1'b0;
          end else begin
            r_hcnt  <= r_hcnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_grant <= 8'h00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_en    = r_en;
  assign o_grant = r_grant;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Testbench for mux8_rr_sched: three instances (MAX_HOLD = 4, 2, 1) share the
// same stimulus; each is compared every cycle against a behavioural model,
// plus a vector table and hand-written corner-case sequences.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;

  logic [2:0] sel_o   [3];
  logic       en_o    [3];
  logic [7:0] grant_o [3];
  logic       busy_o  [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state per instance: phase 0=idle, 1=owned, 2=dead cycle.
  int m_phase [3];
  int m_owner [3];
  int m_ptr   [3];
  int m_held  [3];
  int m_max   [3] = '{4, 2, 1};

  always #5 clk = ~clk;

  mux8_rr_sched #(.MAX_HOLD(4)) u_dut_h4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
    .o_sel(sel_o[0]), .o_en(en_o[0]), .o_grant(grant_o[0]), .o_busy(busy_o[0]));

  mux8_rr_sched #(.MAX_HOLD(2)) u_dut_h2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
    .o_sel(sel_o[1]), .o_en(en_o[1]), .o_grant(grant_o[1]), .o_busy(busy_o[1]));

  mux8_rr_sched #(.MAX_HOLD(1)) u_dut_h1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
    .o_sel(sel_o[2]), .o_en(en_o[2]), .o_grant(grant_o[2]), .o_busy(busy_o[2]));

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] sel;
    logic [7:0] grant;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] dut_vec(input int u);
    return {busy_o[u], en_o[u], sel_o[u], grant_o[u]};
  endfunction

  function automatic logic [12:0] model_vec(input int u);
    logic       g;
    logic [7:0] oh;
    g  = (m_phase[u] == 1);
    oh = g ? (8'(1) << m_owner[u]) : 8'h00;
    return {g, g, 3'(m_owner[u]), oh};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_phase[u] = 0;
      m_owner[u] = 0;
      m_ptr[u]   = 0;
      m_held[u]  = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    int idx;
    for (int u = 0; u < 3; u++) begin
      if (m_phase[u] == 1) begin
        if (d || !r[m_owner[u]] || m_held[u] == m_max[u]) m_phase[u] = 2;
        else m_held[u] = m_held[u] + 1;
      end else begin
        w = -1;
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr[u] + k) % 8;
          if (w < 0 && r[idx]) w = idx;
        end
        if (w >= 0) begin
          m_phase[u] = 1;
          m_owner[u] = w;
          m_held[u]  = 1;
          m_ptr[u]   = (w + 1) % 8;
        end else begin
          m_phase[u] = 0;
        end
      end
    end
  endtask

  // One clock: drive at negedge, model follows the edge, compare at next negedge.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    for (int u = 0; u < 3; u++) chk($sformatf("model_h%0d", m_max[u]), 32'(dut_vec(u)), 32'(model_vec(u)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 8'h00;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) chk("reset_outputs", 32'(dut_vec(u)), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [23];

  initial begin
    // Single requester hold limit, early release, simultaneous causes, idle.
    vecs[0]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[1]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[2]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[3]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[4]  = '{8'h08, 1'b0, 1'b0, 3'd3, 8'h00};
    vecs[5]  = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[6]  = '{8'h12, 1'b0, 1'b0, 3'd3, 8'h00};
    vecs[7]  = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[8]  = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[9]  = '{8'h02, 1'b0, 1'b0, 3'd4, 8'h00};
    vecs[10] = '{8'h02, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[11] = '{8'h12, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[12] = '{8'h12, 1'b1, 1'b0, 3'd1, 8'h00};
    vecs[13] = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[14] = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[15] = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[16] = '{8'h12, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[17] = '{8'h12, 1'b1, 1'b0, 3'd4, 8'h00};
    vecs[18] = '{8'h12, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[19] = '{8'h12, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[20] = '{8'h00, 1'b0, 1'b0, 3'd1, 8'h00};
    vecs[21] = '{8'h00, 1'b0, 1'b0, 3'd1, 8'h00};
    vecs[22] = '{8'h00, 1'b0, 1'b0, 3'd1, 8'h00};

    model_reset();
    do_reset();

    for (int i = 0; i < 23; i++) begin
      cycle(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), 32'({en_o[0], sel_o[0], grant_o[0]}),
          32'({vecs[i].en, vecs[i].sel, vecs[i].grant}));
    end

    // Reset mid-grant with sel = 5, then a fresh grant after release.
    do_reset();
    cycle(8'h20, 1'b0);
    chk("pre_reset_sel5", 32'({en_o[0], sel_o[0]}), 32'({1'b1, 3'd5}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midgrant", 32'(dut_vec(0)), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h01, 1'b0);
    chk("post_reset_grant", 32'({en_o[0], grant_o[0]}), 32'({1'b1, 8'h01}));

    // Idle for 10 cycles, then a wrap scan from ptr 0 grants requester 7.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(8'h00, 1'b0);
      chk("idle_hold", 32'({en_o[0], sel_o[0], busy_o[0]}), 32'({1'b0, 3'd0, 1'b0}));
    end
    cycle(8'h80, 1'b0);
    chk("wrap_grant7", 32'({en_o[0], sel_o[0], grant_o[0]}), 32'({1'b1, 3'd7, 8'h80}));
    cycle(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0);
      chk("idle_sel_held", 32'({en_o[0], sel_o[0]}), 32'({1'b0, 3'd7}));
    end

    // Full rotation with MAX_HOLD = 2: two owned cycles, one dead cycle, per owner.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int ph = 0; ph < 3; ph++) begin
        cycle(8'hFF, 1'b0);
        chk($sformatf("rotate_o%0d_p%0d", i, ph), 32'({en_o[1], sel_o[1]}),
            32'({(ph < 2) ? 1'b1 : 1'b0, 3'(i % 8)}));
      end
    end

    // MAX_HOLD = 1: every grant lasts exactly one cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(8'h01, 1'b0);
      chk("hold1_alt", 32'(en_o[2]), 32'((i % 2 == 0) ? 1 : 0));
    end

    // Randomized traffic against the model, with one reset in the middle.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic       d;
      if (i == 200) do_reset();
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'($urandom) & 8'($urandom);
        2:       r = 8'hFF;
        default: r = 8'($urandom);
      endcase
      d = ($urandom_range(0, 4) == 0);
      cycle(r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares one 8-to-1 multiplexer among eight requesters. Each requester raises a request line. The block grants the mux to one requester at a time and drives the mux select and enable from registers. It bounds how long any requester may hold the mux and inserts one dead cycle between owners. It sits directly in front of the 8-to-1 mux: its `sel` output goes to the mux select and its `en` output goes to the mux enable.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last. Legal range is 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, 8 bits: request lines; bit i means requester i wants the mux.
- `done` input, 1 bit: the current owner releases the mux; sampled only in GRANT.
- `sel` output, 3 bits: mux select, registered; equals the index of the current or last owner.
- `en` output, 1 bit: mux enable, registered; 1 only in GRANT.
- `grant` output, 8 bits: one-hot grant, registered; all zeros outside GRANT.
- `busy` output, 1 bit: 1 while in GRANT.

## Operation
- **States:** IDLE, GRANT, GAP.
- **Internal registers:**
  - 3-bit round-robin pointer `ptr` (next index with highest priority).
  - 8-bit hold counter `hcnt`.
- **Arbitration** runs at any clock edge where the state is IDLE or GAP:
  - Winner = first set bit of `req` scanning `ptr`, `ptr`+1, …, wrapping 7→0.
  - If a winner exists: next state is GRANT; `sel` = winner; `grant` = 1<<winner; `en` = 1; `busy` = 1; `hcnt` = 1; `ptr` = winner+1 mod 8 (7 wraps to 0).
  - If `req` is 0: IDLE stays IDLE; GAP goes to IDLE; outputs stay off.
- **GRANT:** at each edge, release occurs if any of these holds:
  - `done` = 1;
  - `req[sel]` = 0;
  - `hcnt` == `MAX_HOLD`.
- **On release:** next state is GAP; `en`, `grant` and `busy` go to 0; `sel` holds its value.
- **No release:** `hcnt` increments; outputs are unchanged.
- **Simultaneous release causes** (for example `done` together with `hcnt`==`MAX_HOLD`) produce a single release, not two.
- **GAP** always lasts exactly one cycle. It blocks back-to-back ownership changes without a dead cycle.
- **A requester that still wants the mux after release** competes again from GAP. Because `ptr` has advanced, any other requester wins first.
- **`sel` is held when `en` = 0.** It changes only when a new grant is issued.
- **Reset (asynchronous, any state, including mid-grant):**
  - state = IDLE;
  - `ptr` = 0, `hcnt` = 0;
  - `sel` = 3'b000, `en` = 0, `grant` = 8'h00, `busy` = 0.

## Timing
- **Latency:** `req` seen at edge k in IDLE → `grant`, `sel`, `en` valid after edge k (1 cycle).
- **Owner-to-owner handoff:** release edge → GAP for one cycle → next owner's grant visible after the following edge.
- **Minimum handoff gap:** 1 cycle with `en` = 0.
- **Hold bound:** a grant lasts at most `MAX_HOLD` cycles with `en` = 1.
  - With `MAX_HOLD` = 1, every grant lasts exactly 1 cycle.
- **Reset release:** the first arbitration occurs at the first rising edge after `rst_n` rises.
- **Outputs are registered:** there is no combinational path from `req` or `done` to any output.
- **`req` changes mid-GRANT for non-owners** have no effect until the next arbitration.

## Test plan
- **Reset mid-grant:** in GRANT with `sel`=5, drive `rst_n`=0 → immediately `en`=0, `grant`=8'h00, `sel`=0, `busy`=0. After release, `req`=8'h01 → grant 8'h01 one cycle later.
- **Single requester with hold limit:** `MAX_HOLD`=4, `req`=8'h08 held constantly, `done`=0 → `en`=1 with `sel`=3 for exactly 4 cycles, then 1 GAP cycle, then `sel`=3 granted again, repeating.
- **Full rotation:** `req`=8'hFF constantly, `MAX_HOLD`=2 → `sel` sequence 0,1,…,7,0. Each grant lasts 2 cycles followed by 1 GAP cycle; `ptr` wraps 7→0.
- **Early release:** `req`=8'h12, `MAX_HOLD`=4.
  - Owner 1 asserts `done` on its 2nd grant cycle → GAP next cycle, then `sel`=4 is granted.
  - Dropping `req[4]` during its grant → release on the next edge.
- **Simultaneous release causes:** `done`=1 on the same edge where `hcnt`==`MAX_HOLD` → exactly one GAP cycle and no skipped requester.
- **Idle behaviour:** `req`=0 for 10 cycles → stays IDLE with `en`=0 and `sel` holding its last value. Then `req`=8'h80 with `ptr`=0 → wrap scan grants `sel`=7.
